// File: rtl/special_item_placer_if.sv
// Signal bundle between the special item placer, the maze wall RAM, the player
// tracker and the special-box draw stage.
interface special_item_placer_if;
  logic       start;
  logic [4:0] playerX;
  logic [4:0] playerY;
  logic       playerMoved;
  logic [8:0] mazeAddr;
  logic       mazeWall;
  logic [4:0] xPlus;
  logic [4:0] yPlus;
  logic [4:0] xMinus;
  logic [4:0] yMinus;
  // drawSpecial is a request that stays high until done is sampled high while
  // drawing; the request drops the cycle after that sample, and done is ignored otherwise.
  logic       drawSpecial;
  logic       done;
  logic       plusHit;
  logic       minusHit;
  logic       busy;
  logic [3:0] state_dbg;

  modport slave (
    input  start, playerX, playerY, playerMoved, mazeWall, done,
    output mazeAddr, xPlus, yPlus, xMinus, yMinus, drawSpecial,
           plusHit, minusHit, busy, state_dbg
  );

  modport master (
    output start, playerX, playerY, playerMoved, mazeWall, done,
    input  mazeAddr, xPlus, yPlus, xMinus, yMinus, drawSpecial,
           plusHit, minusHit, busy, state_dbg
  );
endinterface

// File: rtl/special_item_placer.sv
// Places the plus/minus special items on open maze cells from an LFSR sequence,
// hands them to the draw stage, then reports when the player steps on one.
module special_item_placer #(
  parameter int         GRID_W    = 16,
  parameter int         GRID_H    = 16,
  parameter int         EXIT_X    = 15,
  parameter int         EXIT_Y    = 15,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                  clk,
  input  logic                  resetn,
  special_item_placer_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_PICK_P = 4'd1,
    S_READ_P = 4'd2,
    S_CHK_P  = 4'd3,
    S_PICK_M = 4'd4,
    S_READ_M = 4'd5,
    S_CHK_M  = 4'd6,
    S_DRAW   = 4'd7,
    S_ARMED  = 4'd8
  } state_t;

  localparam logic [4:0] GRID_W5 = 5'(GRID_W);
  localparam logic [4:0] GRID_H5 = 5'(GRID_H);
  localparam logic [4:0] EXIT_X5 = 5'(EXIT_X);
  localparam logic [4:0] EXIT_Y5 = 5'(EXIT_Y);
  localparam logic [8:0] GRID_W9 = 9'(GRID_W);

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [4:0] cx_q, cx_d;
  logic [4:0] cy_q, cy_d;
  logic [4:0] x_plus_q, x_plus_d;
  logic [4:0] y_plus_q, y_plus_d;
  logic [4:0] x_minus_q, x_minus_d;
  logic [4:0] y_minus_q, y_minus_d;
  logic       draw_q, draw_d;
  logic       plus_hit_q, plus_hit_d;
  logic       minus_hit_q, minus_hit_d;
  logic       busy_q, busy_d;

  logic [7:0] lfsr_next;
  logic       cand_ok;
  logic       on_plus;
  logic       on_minus;

  always_comb begin
    lfsr_next = lfsr_q[0] ? ({1'b0, lfsr_q[7:1]} ^ 8'hB8) : {1'b0, lfsr_q[7:1]};
    // Basic rejection shared by both items; the minus check adds the plus cell.
    cand_ok = !((cx_q >= GRID_W5) || (cy_q >= GRID_H5) || bus.mazeWall ||
                ((cx_q == bus.playerX) && (cy_q == bus.playerY)) ||
                ((cx_q == EXIT_X5) && (cy_q == EXIT_Y5)));
    on_plus  = (bus.playerX == x_plus_q)  && (bus.playerY == y_plus_q);
    on_minus = (bus.playerX == x_minus_q) && (bus.playerY == y_minus_q);

    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    x_plus_d    = x_plus_q;
    y_plus_d    = y_plus_q;
    x_minus_d   = x_minus_q;
    y_minus_d   = y_minus_q;
    plus_hit_d  = 1'b0;
    minus_hit_d = 1'b0;

    if (bus.start) begin
      state_d = S_PICK_P;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_PICK_P, S_PICK_M: begin
          cx_d    = {1'b0, lfsr_q[3:0]};
          cy_d    = {1'b0, lfsr_q[7:4]};
          lfsr_d  = lfsr_next;
          state_d = (state_q == S_PICK_P) ? S_READ_P : S_READ_M;
        end
        S_READ_P: state_d = S_CHK_P;
        S_READ_M: state_d = S_CHK_M;
        S_CHK_P: begin
          if (cand_ok) begin
            x_plus_d = cx_q;
            y_plus_d = cy_q;
            state_d  = S_PICK_M;
          end else begin
            state_d = S_PICK_P;
          end
        end
        S_CHK_M: begin
          if (cand_ok && !((cx_q == x_plus_q) && (cy_q == y_plus_q))) begin
            x_minus_d = cx_q;
            y_minus_d = cy_q;
            state_d   = S_DRAW;
          end else begin
            state_d = S_PICK_M;
          end
        end
        S_DRAW: begin
          if (bus.done) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (bus.playerMoved) begin
            if (on_plus) begin
              plus_hit_d = 1'b1;
              state_d    = S_PICK_P;
            end else if (on_minus) begin
              minus_hit_d = 1'b1;
              state_d     = S_PICK_P;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs follow the next state so they line up with the registered state.
    draw_d = (state_d == S_DRAW);
    busy_d = (state_d != S_IDLE) && (state_d != S_ARMED);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      cx_q        <= '0;
      cy_q        <= '0;
      x_plus_q    <= '0;
      y_plus_q    <= '0;
      x_minus_q   <= '0;
      y_minus_q   <= '0;
      draw_q      <= 1'b0;
      plus_hit_q  <= 1'b0;
      minus_hit_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      x_plus_q    <= x_plus_d;
      y_plus_q    <= y_plus_d;
      x_minus_q   <= x_minus_d;
      y_minus_q   <= y_minus_d;
      draw_q      <= draw_d;
      plus_hit_q  <= plus_hit_d;
      minus_hit_q <= minus_hit_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mazeAddr    = ({4'b0, cy_q} * GRID_W9) + {4'b0, cx_q};
  assign bus.xPlus       = x_plus_q;
  assign bus.yPlus       = y_plus_q;
  assign bus.xMinus      = x_minus_q;
  assign bus.yMinus      = y_minus_q;
  assign bus.drawSpecial = draw_q;
  assign bus.plusHit     = plus_hit_q;
  assign bus.minusHit    = minus_hit_q;
  assign bus.busy        = busy_q;
  assign bus.state_dbg   = state_q;

endmodule
